// File: rtl/spr_dma_ctrl.sv
// rtl/spr_dma_ctrl.sv - sprite (OAM) DMA engine snooping $4014 writes, copying a 256-byte page to $2004
// Optional feature macro: SPR_DMA_ALIGN_EN (parity flop + ALIGN state)
module spr_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy
);

`ifdef SPR_DMA_ALIGN_EN
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_READ, S_WRITE} state_t;
`endif

  state_t      r_state;
  logic        r_busy;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_buf;
  logic        w_trigger;

  assign w_trigger = cpu_wen && (cpu_addr_out == DMA_REG_ADDR);

`ifdef SPR_DMA_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) r_parity <= 1'b0;
    else        r_parity <= ~r_parity;
  end
`endif

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_buf   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_data_out;
            r_idx   <= 8'h00;
            r_busy  <= 1'b1;
            r_state <= S_HALT;
          end
        end
`ifdef SPR_DMA_ALIGN_EN
        // Parity during HALT is the inverse of parity at the trigger edge; a trigger
        // on parity 1 gets an ALIGN cycle so the first READ always lands on parity 0.
        S_HALT:  r_state <= r_parity ? S_READ : S_ALIGN;
        S_ALIGN: r_state <= S_READ;
`else
        S_HALT:  r_state <= S_READ;
`endif
        S_READ: begin
          r_buf   <= mem_rdata;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_idx == 8'hFF) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_READ;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdy  = ~r_busy;
  assign dma_busy = r_busy;

  // While busy the CPU bus is fully isolated from memory.
  always_comb begin
    mem_addr  = cpu_addr_out;
    mem_wdata = cpu_data_out;
    mem_wen   = cpu_wen;
    mem_ren   = cpu_ren;
    if (r_busy) begin
      mem_addr  = {r_page, r_idx};
      mem_wdata = r_buf;
      mem_wen   = 1'b0;
      mem_ren   = (r_state == S_READ);
      if (r_state == S_WRITE) begin
        mem_addr = OAM_DATA_ADDR;
        mem_wen  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// tb/tb_spr_dma_ctrl.sv - scoreboard bench for spr_dma_ctrl with a behavioural page-copy model
module tb_spr_dma_ctrl;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_wen;
  logic        cpu_ren;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_rdata;
  logic        dma_busy;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          edge_cnt;
  bit          first_rd = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  spr_dma_ctrl dut (
    .clk(clk), .b_rst(b_rst),
    .cpu_addr_out(cpu_addr_out), .cpu_data_out(cpu_data_out),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .dma_busy(dma_busy)
  );

  // Cycle count since reset release; its LSB is the expected alignment parity.
  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected DUT activity at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (b_rst) begin
      chk("busy_eq_not_rdy", dma_busy, !cpu_rdy);
      if (dma_busy && mem_ren) begin
        chk("read_no_wen", mem_wen, 0);
        if (rd_q.size() == 0) bad("unexpected_read");
        else begin
          chk("read_addr", mem_addr, rd_q.pop_front());
          if (first_rd) begin
            first_rd = 0;
`ifdef SPR_DMA_ALIGN_EN
            chk("first_read_parity", edge_cnt % 2, 0);
`endif
          end
        end
      end
      if (dma_busy && mem_wen) begin
        wr_cnt++;
        if (wr_q.size() == 0) bad("unexpected_oam_write");
        else begin
          chk("oam_addr", mem_addr, 16'h2004);
          chk("oam_data", mem_wdata, wr_q.pop_front());
        end
      end
    end
  end

  task automatic bus_idle();
    cpu_addr_out = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_wen      = 1'b0;
    cpu_ren      = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] page, input int want_par, output int ptrig);
    int guard = 0;
    @(negedge clk);
    while (want_par >= 0 && (edge_cnt % 2) != want_par && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    cpu_addr_out = 16'h4014;
    cpu_data_out = page;
    cpu_wen      = 1'b1;
    cpu_ren      = 1'b0;
    ptrig        = edge_cnt % 2;
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({page, 8'(i)});
      wr_q.push_back(mem[{page, 8'(i)}]);
    end
    first_rd = 1;
  endtask

  task automatic run_dma(input logic [7:0] page, input int want_par);
    int ptrig, n, exp_len;
    bit done = 0;
    start_dma(page, want_par, ptrig);
`ifdef SPR_DMA_ALIGN_EN
    exp_len = 513 + ptrig;
`else
    exp_len = 513;
`endif
    n = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (!cpu_rdy) begin
        n++;
        cpu_addr_out = 16'($urandom);
        if (cpu_addr_out == 16'h4014) cpu_addr_out = 16'h4015;
        cpu_data_out = 8'($urandom);
        cpu_wen      = 1'($urandom);
        cpu_ren      = 1'($urandom);
        if (n == 200) begin
          cpu_addr_out = 16'h4014;
          cpu_data_out = 8'h07;
          cpu_wen      = 1'b1;
        end
      end else begin
        done = 1;
      end
    end
    bus_idle();
    chk("transfer_done", done, 1);
    chk("stall_cycles", n, exp_len);
    chk("read_q_drained", rd_q.size(), 0);
    chk("write_q_drained", wr_q.size(), 0);
    #1;
    chk("idle_busy", dma_busy, 0);
    chk("idle_passthru_addr", mem_addr, cpu_addr_out);
  endtask

  task automatic abort_dma(input logic [7:0] page);
    int ptrig, start;
    bit hit = 0;
    start = wr_cnt;
    start_dma(page, -1, ptrig);
    @(negedge clk);
    bus_idle();
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      #2;
      if (wr_cnt - start >= 100) hit = 1;
    end
    chk("abort_reached_100", hit, 1);
    @(posedge clk);
    #2;
    b_rst = 1'b0;
    #1;
    chk("abort_rdy", cpu_rdy, 1);
    chk("abort_busy", dma_busy, 0);
    rd_q.delete();
    wr_q.delete();
    first_rd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_write", mem_wen, 0);
    end
    chk("abort_write_count", wr_cnt - start, 100);
    b_rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    b_rst        = 1'b0;
    cpu_addr_out = 16'h1234;
    cpu_data_out = 8'h77;
    cpu_wen      = 1'b1;
    cpu_ren      = 1'b0;
    #12;
    chk("reset_rdy", cpu_rdy, 1);
    chk("reset_busy", dma_busy, 0);
    chk("reset_passthru_addr", mem_addr, 16'h1234);
    chk("reset_passthru_wdata", mem_wdata, 8'h77);
    chk("reset_passthru_wen", mem_wen, 1);
    @(negedge clk);
    bus_idle();
    b_rst = 1'b1;

    for (int k = 0; k < 24; k++) begin
      logic [15:0] a;
      @(negedge clk);
      case (k % 4)
        0: a = 16'h4016;
        1: a = 16'h2004;
        2: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      if (a == 16'h4014) a = 16'h4013;
      cpu_addr_out = a;
      cpu_data_out = 8'($urandom);
      cpu_wen      = (k % 4 == 2) ? 1'b0 : 1'($urandom);
      cpu_ren      = (k % 4 == 2) ? 1'b1 : 1'($urandom);
      #1;
      chk("pt_addr", mem_addr, a);
      chk("pt_wdata", mem_wdata, cpu_data_out);
      chk("pt_wen", mem_wen, cpu_wen);
      chk("pt_ren", mem_ren, cpu_ren);
      chk("pt_busy", dma_busy, 0);
    end
    bus_idle();

    run_dma(8'h02, 0);
    run_dma(8'h02, 1);
    run_dma(8'hFF, -1);
    abort_dma(8'h02);
    run_dma(8'h02, -1);
    for (int r = 0; r < 3; r++) run_dma(8'($urandom), int'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spr_dma_ctrl.md
# spr_dma_ctrl

Sprite (OAM) DMA engine between the CPU and the memory/IO subsystem. Snoops CPU writes to the SPR-RAM DMA register ($4014). On each such write it halts the CPU and copies the 256-byte page `XX00h`–`XXFFh` to the SPR-RAM data register ($2004), one byte at a time, through the memory bus. When idle it is a transparent pass-through of the CPU bus to memory.

## Interface
Parameters:
- `DMA_REG_ADDR`, default 16'h4014: trigger register address.
- `OAM_DATA_ADDR`, default 16'h2004: destination register for every DMA write.

Ports:
- `clk`, in, 1: system clock; the single clock domain.
- `b_rst`, in, 1: reset. **Asynchronous assert, active-low.**
- `cpu_addr_out`, in, 16: CPU address.
- `cpu_data_out`, in, 8: CPU write data.
- `cpu_wen`, in, 1: CPU write strobe.
- `cpu_ren`, in, 1: CPU read strobe.
- `cpu_rdy`, out, 1: 0 halts the CPU; the CPU holds its bus while this is 0.
- `mem_addr`, out, 16: address to the memory/IO subsystem.
- `mem_wdata`, out, 8: write data to memory.
- `mem_wen`, out, 1: write strobe to memory.
- `mem_ren`, out, 1: read strobe to memory.
- `mem_rdata`, in, 8: read data from memory, valid combinationally in the same cycle as `mem_ren`.
- `dma_busy`, out, 1: 1 in any state other than IDLE.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE behaviour:
  - `mem_*` equal the CPU signals combinationally; `cpu_rdy`=1.
- Trigger:
  - A write with `cpu_addr_out==DMA_REG_ADDR` and `cpu_wen`=1, sampled at a posedge in IDLE, latches `page<=cpu_data_out`, clears `idx`, and moves to HALT.
  - The trigger write itself still passes through to memory.
- HALT: one cycle; `cpu_rdy`=0; no memory access.
- HALT exit:
  - If `parity`=1, go to ALIGN (one idle cycle).
  - Otherwise go to READ.
- READ:
  - Drives `mem_addr={page,idx}`, `mem_ren`=1, `mem_wen`=0.
  - Captures `mem_rdata` into `buf` at the posedge.
  - Goes to WRITE.
- WRITE:
  - Drives `mem_addr=OAM_DATA_ADDR`, `mem_wdata=buf`, `mem_wen`=1, `mem_ren`=0.
  - If `idx`==8'hFF, go to IDLE; else `idx<=idx+1` and go to READ.
- Address arithmetic: `idx` is 8 bits; the page never increments. Page 8'hFF reads FF00h–FFFFh, with no carry into 0000h.
- `parity`: a free-running flop that toggles every cycle from reset release; reset value 0.
- CPU bus while `dma_busy`=1:
  - `cpu_wen`/`cpu_ren`/`cpu_addr_out` are ignored and never reach memory.
  - A further $4014 write is ignored; there is no re-trigger.
- Reset values:
  - `cpu_rdy`=1, `dma_busy`=0, state IDLE.
  - `page`=0, `idx`=0, `buf`=0, `parity`=0.
  - `mem_*` are in pass-through.
- Reset asserted mid-transfer:
  - Immediate abort; outputs return to their reset values.
  - No further $2004 writes; the partial OAM contents are left as-is.

## Timing
- Trigger write at posedge T0 → HALT during cycle T0+1 (`cpu_rdy`=0 from T0+1).
- Transfer length, counted from the HALT cycle to the last WRITE cycle inclusive:
  - 513 cycles when no ALIGN cycle is inserted.
  - 514 cycles when an ALIGN cycle is inserted.
- First READ is always on `parity`=0 when alignment is compiled in.
- Byte n: READ of `{page,n}` in one cycle, WRITE of the same byte to $2004 in the next. Data latency is one cycle.
- `cpu_rdy` returns to 1 in the cycle after the final WRITE; IDLE pass-through resumes in that same cycle.
- `dma_busy` equals `~cpu_rdy` at all times.

## Configuration
- `SPR_DMA_ALIGN_EN` defined:
  - `parity` flop and ALIGN state present.
  - Transfer is 513/514 cycles depending on parity.
- `SPR_DMA_ALIGN_EN` undefined:
  - No `parity` flop, no ALIGN state; HALT always goes to READ.
  - Transfer is always 513 cycles.

## Test plan
- Preload mem[0200h+i]=i^8'h5A; write 8'h02 to $4014 with `parity`=0 at trigger → 256 writes to $2004 with data 5A,5B,…,A5 in order; `cpu_rdy`=0 for exactly 513 cycles.
- Same stimulus with `parity`=1 at trigger (`SPR_DMA_ALIGN_EN` defined) → 514 stall cycles; first READ on even parity. Undefined → 513.
- Write 8'hFF to $4014 → reads span FF00h–FFFFh; no access to 0000h; returns to IDLE after idx FF.
- Deassert `b_rst` after the 100th $2004 write → `cpu_rdy`=1 and `dma_busy`=0 immediately (asynchronous); no further $2004 writes; a new $4014 write after reset restarts from idx 0.
- CPU writes to $4016 and $2004 and reads $8000 in IDLE → `mem_*` mirror the CPU bus exactly; `dma_busy` stays 0.
- Assert `cpu_wen` to $4014 with data 8'h07 during an active transfer → ignored; the page stays the original; transfer length unchanged.
